// File: rtl/mole_pkg.sv
// Shared constants for the Whack-A-Mole round sequencer.
//   - FSM state encodings (legacy-style localparams over a 2-bit type)
//   - LFSR feedback mask for x^16 + x^14 + x^13 + x^11
//   - mole count and index width
//   - lfsr_step(): one Galois (right-shifting) LFSR advance
package mole_pkg;

  localparam int unsigned NumMoles = 16;
  localparam int unsigned IdxW     = 4;

  localparam logic [15:0] LfsrTaps = 16'hB400;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StGap  = 2'd1;
  localparam state_t StUp   = 2'd2;
  localparam state_t StDone = 2'd3;

  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return {1'b0, q[15:1]} ^ (q[0] ? LfsrTaps : 16'h0000);
  endfunction

endpackage

// File: rtl/mole_lfsr16.sv
// 16-bit Galois LFSR used to pick the next mole.
// Ports:
//   clock  - system clock
//   reset  - synchronous active-high; loads seed
//   seed   - reset value (must be nonzero)
//   q      - current LFSR state, advances every non-reset cycle
module mole_lfsr16
  import mole_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= seed;
    end else begin
      q <= lfsr_step(q);
    end
  end

endmodule

// File: rtl/mole_round_ctrl.sv
// Sequencer for one Whack-A-Mole round: lights one mole at a time, times the
// up-window and the dark gap, detects hits on the matching button, and counts
// hits and misses until the round's moles are used up.
// Ports:
//   clock, reset  - system clock, synchronous active-high reset
//   start         - one-cycle pulse, begins a round (ignored while busy)
//   buttons       - debounced button levels, bit i = mole i
//   led           - one-hot active mole, 0 when none
//   mole_idx      - index of the current or last mole
//   score         - hits this round (saturating)
//   misses        - timeouts this round (saturating)
//   moles_left    - moles not yet presented or resolved
//   busy          - high in GAP and UP
//   done          - round finished, held until next start
// All outputs come straight from registers.
module mole_round_ctrl
  import mole_pkg::*;
#(
  parameter int unsigned NUM_MOLES   = NumMoles,
  parameter int unsigned TICK_DIV    = 50000,
  parameter int unsigned UP_TIME_MS  = 800,
  parameter int unsigned GAP_TIME_MS = 200,
  parameter int unsigned ROUND_MOLES = 30,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_MOLES-1:0] buttons,
  output logic [NUM_MOLES-1:0] led,
  output logic [IdxW-1:0]      mole_idx,
  output logic [31:0]          score,
  output logic [7:0]           misses,
  output logic [7:0]           moles_left,
  output logic                 busy,
  output logic                 done
);

  localparam logic [31:0] GapLast   = 32'(GAP_TIME_MS * TICK_DIV - 1);
  localparam logic [31:0] UpLast    = 32'(UP_TIME_MS * TICK_DIV - 1);
  localparam logic [7:0]  RoundInit = 8'(ROUND_MOLES);

  state_t               state_q, state_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [NUM_MOLES-1:0] btn_prev_q;
  logic [NUM_MOLES-1:0] led_q, led_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [31:0]          score_q, score_d;
  logic [7:0]           misses_q, misses_d;
  logic [7:0]           left_q, left_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [15:0]          lfsr;
  logic [NUM_MOLES-1:0] hit_vec;
  logic                 hit;
  logic [IdxW-1:0]      pick;

  mole_lfsr16 u_lfsr (
    .clock (clock),
    .reset (reset),
    .seed  (LFSR_SEED),
    .q     (lfsr)
  );

  assign hit_vec = buttons & ~btn_prev_q;
  assign hit     = hit_vec[idx_q];
  // Never repeat the previous mole: bump a colliding pick to the next index.
  assign pick    = (lfsr[IdxW-1:0] == idx_q) ? lfsr[IdxW-1:0] + 1'b1 : lfsr[IdxW-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    led_d    = led_q;
    idx_d    = idx_q;
    score_d  = score_q;
    misses_d = misses_q;
    left_d   = left_q;
    busy_d   = busy_q;
    done_d   = done_q;
    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d  = StGap;
          cnt_d    = '0;
          score_d  = '0;
          misses_d = '0;
          left_d   = RoundInit;
          busy_d   = 1'b1;
          done_d   = 1'b0;
        end
      end
      StGap: begin
        if (cnt_q == GapLast) begin
          state_d     = StUp;
          cnt_d       = '0;
          idx_d       = pick;
          led_d       = '0;
          led_d[pick] = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StUp: begin
        // A hit on the final cycle takes priority over the timeout.
        if (hit || (cnt_q == UpLast)) begin
          if (hit) begin
            score_d = (score_q == 32'hFFFF_FFFF) ? score_q : score_q + 32'd1;
          end else begin
            misses_d = (misses_q == 8'hFF) ? misses_q : misses_q + 8'd1;
          end
          led_d  = '0;
          cnt_d  = '0;
          left_d = left_q - 8'd1;
          if (left_q == 8'd1) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = StGap;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      // All-ones so buttons held through reset never look like a press.
      btn_prev_q <= '1;
      led_q      <= '0;
      idx_q      <= '0;
      score_q    <= '0;
      misses_q   <= '0;
      left_q     <= RoundInit;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      btn_prev_q <= buttons;
      led_q      <= led_d;
      idx_q      <= idx_d;
      score_q    <= score_d;
      misses_q   <= misses_d;
      left_q     <= left_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign led        = led_q;
  assign mole_idx   = idx_q;
  assign score      = score_q;
  assign misses     = misses_q;
  assign moles_left = left_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Directed bench for mole_round_ctrl with short timing parameters
// (GAP = 4 cycles, UP = 10 cycles, 3 moles per round). An independent LFSR
// model predicts each mole pick.
module tb_mole_round_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [15:0] buttons = 16'h0000;
  logic [15:0] led;
  logic [3:0]  mole_idx;
  logic [31:0] score;
  logic [7:0]  misses;
  logic [7:0]  moles_left;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m_lfsr = 16'hACE1;
  logic [15:0] m_prev = 16'hACE1;
  logic [3:0]  exp_idx = 4'd0;
  logic [3:0]  prev_idx = 4'd0;
  logic [15:0] exp_led = 16'h0000;

  mole_round_ctrl #(
    .NUM_MOLES   (16),
    .TICK_DIV    (2),
    .UP_TIME_MS  (5),
    .GAP_TIME_MS (2),
    .ROUND_MOLES (3),
    .LFSR_SEED   (16'hACE1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .buttons    (buttons),
    .led        (led),
    .mole_idx   (mole_idx),
    .score      (score),
    .misses     (misses),
    .moles_left (moles_left),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;

  // Reference LFSR; m_prev holds the value the DUT saw before the last edge.
  always @(posedge clock) begin
    m_prev <= m_lfsr;
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic predict();
    logic [3:0] p;
    p = m_prev[3:0];
    if (p == exp_idx) p = p + 4'd1;
    prev_idx = exp_idx;
    exp_idx  = p;
    exp_led  = 16'd1 << p;
  endtask

  task automatic wait_lit(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (led != 16'h0000) begin
        ok = 1'b1;
        predict();
        break;
      end
    end
  endtask

  task automatic apply_reset(input logic [15:0] b);
    reset   = 1'b1;
    start   = 1'b0;
    buttons = b;
    cyc();
    cyc();
    reset   = 1'b0;
    exp_idx = 4'd0;
  endtask

  task automatic test_reset();
    apply_reset(16'h0000);
    n_vec++; if (led !== 16'h0) begin n_err++; $display("FAIL rst_led: got %0h want 0", led); end
    n_vec++; if (mole_idx !== 4'd0) begin n_err++; $display("FAIL rst_idx: got %0d want 0", mole_idx); end
    n_vec++; if (score !== 32'd0) begin n_err++; $display("FAIL rst_score: got %0d want 0", score); end
    n_vec++; if (misses !== 8'd0) begin n_err++; $display("FAIL rst_miss: got %0d want 0", misses); end
    n_vec++; if (moles_left !== 8'd3) begin n_err++; $display("FAIL rst_left: got %0d want 3", moles_left); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", done); end
  endtask

  task automatic test_start_gap();
    start = 1'b1;
    cyc();
    start = 1'b0;
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL start_busy: got %b want 1", busy); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) cyc();
      n_vec++;
      if (led !== 16'h0) begin n_err++; $display("FAIL gap_dark[%0d]: got %0h want 0", i, led); end
    end
    cyc();
    predict();
    n_vec++; if (led !== exp_led) begin n_err++; $display("FAIL first_led: got %0h want %0h", led, exp_led); end
    n_vec++; if (mole_idx !== exp_idx) begin n_err++; $display("FAIL first_idx: got %0d want %0d", mole_idx, exp_idx); end
  endtask

  task automatic test_hit();
    for (int i = 0; i < 3; i++) cyc();
    n_vec++; if (led !== exp_led) begin n_err++; $display("FAIL hit_prelit: got %0h want %0h", led, exp_led); end
    buttons[exp_idx] = 1'b1;
    cyc();
    buttons = 16'h0000;
    n_vec++; if (led !== 16'h0) begin n_err++; $display("FAIL hit_led: got %0h want 0", led); end
    n_vec++; if (score !== 32'd1) begin n_err++; $display("FAIL hit_score: got %0d want 1", score); end
    n_vec++; if (moles_left !== 8'd2) begin n_err++; $display("FAIL hit_left: got %0d want 2", moles_left); end
    n_vec++; if (misses !== 8'd0) begin n_err++; $display("FAIL hit_miss: got %0d want 0", misses); end
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_vec++;
      if (led !== 16'h0) begin n_err++; $display("FAIL hit_gap[%0d]: got %0h want 0", i, led); end
    end
    cyc();
    predict();
    n_vec++; if (led !== exp_led) begin n_err++; $display("FAIL second_led: got %0h want %0h", led, exp_led); end
    n_vec++; if (mole_idx !== exp_idx) begin n_err++; $display("FAIL second_idx: got %0d want %0d", mole_idx, exp_idx); end
  endtask

  task automatic test_timeout();
    bit ok;
    int lit;
    apply_reset(16'h0000);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int m = 0; m < 3; m++) begin
      wait_lit(ok);
      n_vec++; if (!ok) begin n_err++; $display("FAIL to_wait[%0d]: got no led want lit", m); end
      n_vec++; if (led !== exp_led) begin n_err++; $display("FAIL to_led[%0d]: got %0h want %0h", m, led, exp_led); end
      lit = 1;
      for (int i = 0; i < 30 && led != 16'h0; i++) begin
        cyc();
        if (led != 16'h0) lit++;
      end
      n_vec++; if (lit != 10) begin n_err++; $display("FAIL to_width[%0d]: got %0d want 10", m, lit); end
    end
    n_vec++; if (misses !== 8'd3) begin n_err++; $display("FAIL to_miss: got %0d want 3", misses); end
    n_vec++; if (score !== 32'd0) begin n_err++; $display("FAIL to_score: got %0d want 0", score); end
    n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL to_done: got %b want 1", done); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL to_busy: got %b want 0", busy); end
    n_vec++; if (moles_left !== 8'd0) begin n_err++; $display("FAIL to_left: got %0d want 0", moles_left); end
    n_vec++; if (mole_idx !== exp_idx) begin n_err++; $display("FAIL to_idx_hold: got %0d want %0d", mole_idx, exp_idx); end
  endtask

  task automatic test_ignore();
    bit ok;
    logic [3:0] nm;
    apply_reset(16'hFFFF);
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_lit(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL ig_wait: got no led want lit"); end
    nm = exp_idx ^ 4'd1;
    buttons[nm] = 1'b0;
    cyc();
    buttons[nm] = 1'b1;
    cyc();
    cyc();
    n_vec++; if (score !== 32'd0) begin n_err++; $display("FAIL ig_score: got %0d want 0", score); end
    n_vec++; if (led !== exp_led) begin n_err++; $display("FAIL ig_led: got %0h want %0h", led, exp_led); end
    buttons[exp_idx] = 1'b0;
    cyc();
    n_vec++; if (led !== exp_led) begin n_err++; $display("FAIL ig_release: got %0h want %0h", led, exp_led); end
    buttons[exp_idx] = 1'b1;
    cyc();
    buttons = 16'h0000;
    n_vec++; if (led !== 16'h0) begin n_err++; $display("FAIL ig_hit_led: got %0h want 0", led); end
    n_vec++; if (score !== 32'd1) begin n_err++; $display("FAIL ig_hit_score: got %0d want 1", score); end
  endtask

  task automatic test_coincide();
    bit ok;
    wait_lit(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL co_wait: got no led want lit"); end
    for (int i = 0; i < 9; i++) cyc();
    n_vec++; if (led !== exp_led) begin n_err++; $display("FAIL co_last_lit: got %0h want %0h", led, exp_led); end
    buttons[exp_idx] = 1'b1;
    cyc();
    buttons = 16'h0000;
    n_vec++; if (led !== 16'h0) begin n_err++; $display("FAIL co_led: got %0h want 0", led); end
    n_vec++; if (score !== 32'd2) begin n_err++; $display("FAIL co_score: got %0d want 2", score); end
    n_vec++; if (misses !== 8'd0) begin n_err++; $display("FAIL co_miss: got %0d want 0", misses); end
    n_vec++; if (moles_left !== 8'd1) begin n_err++; $display("FAIL co_left: got %0d want 1", moles_left); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    start = 1'b1;
    cyc();
    start = 1'b0;
    n_vec++; if (moles_left !== 8'd1) begin n_err++; $display("FAIL busy_start_left: got %0d want 1", moles_left); end
    n_vec++; if (score !== 32'd2) begin n_err++; $display("FAIL busy_start_score: got %0d want 2", score); end
    n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL busy_start_busy: got %b want 1", busy); end
    wait_lit(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL mid_wait: got no led want lit"); end
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    n_vec++; if (led !== 16'h0) begin n_err++; $display("FAIL mid_led: got %0h want 0", led); end
    n_vec++; if (mole_idx !== 4'd0) begin n_err++; $display("FAIL mid_idx: got %0d want 0", mole_idx); end
    n_vec++; if (score !== 32'd0) begin n_err++; $display("FAIL mid_score: got %0d want 0", score); end
    n_vec++; if (misses !== 8'd0) begin n_err++; $display("FAIL mid_miss: got %0d want 0", misses); end
    n_vec++; if (moles_left !== 8'd3) begin n_err++; $display("FAIL mid_left: got %0d want 3", moles_left); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", busy); end
    n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL mid_done: got %b want 0", done); end
    reset   = 1'b0;
    exp_idx = 4'd0;
  endtask

  task automatic test_back_to_back();
    bit ok;
    for (int r = 0; r < 200; r++) begin
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int m = 0; m < 3; m++) begin
        wait_lit(ok);
        n_vec++; if (!ok) begin n_err++; $display("FAIL b2b_wait[%0d.%0d]: got no led", r, m); end
        n_vec++;
        if (mole_idx !== exp_idx) begin
          n_err++; $display("FAIL b2b_idx[%0d.%0d]: got %0d want %0d", r, m, mole_idx, exp_idx);
        end
        n_vec++;
        if (mole_idx === prev_idx) begin
          n_err++; $display("FAIL b2b_repeat[%0d.%0d]: got %0d want not %0d", r, m, mole_idx, prev_idx);
        end
        buttons = exp_led;
        cyc();
        buttons = 16'h0000;
      end
      n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL b2b_done[%0d]: got %b want 1", r, done); end
      n_vec++; if (score !== 32'd3) begin n_err++; $display("FAIL b2b_score[%0d]: got %0d want 3", r, score); end
    end
  endtask

  initial begin
    test_reset();
    test_start_gap();
    test_hit();
    test_timeout();
    test_ignore();
    test_coincide();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
